// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin owner of one shared arbitrary_counter32.
// Grants one requester job at a time, programs the counter, runs it for the
// requested number of enabled cycles and returns the final value tagged
// with the requester index.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for any req_valid; grant is issued in this state
// S_LOAD    | clr pulse, counter loads min (inc) or max (dec)
// S_RUN     | cnten high for exactly ticks cycles
// S_CAPTURE | counter stopped, cnt_value sampled into rsp_value
// S_RESP    | rsp_valid held until rsp_ready
module counter_scheduler #(
  parameter int NREQ  = 4,
  parameter int TICKW = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [32*NREQ-1:0]    req_min,
  input  logic [32*NREQ-1:0]    req_max,
  input  logic [NREQ-1:0]       req_dir,
  input  logic [TICKW*NREQ-1:0] req_ticks,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2:0]            rsp_id,
  output logic [31:0]           rsp_value,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [31:0]           cnt_min,
  output logic [31:0]           cnt_max,
  output logic                  inc_dec,
  output logic                  clr,
  output logic                  cnten,
  input  logic [31:0]           cnt_value
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       rr_ptr;
  logic [TICKW-1:0] tick_cnt;

  logic             gnt_any;
  logic [2:0]       gnt_idx;
  logic [NREQ-1:0]  gnt_oh;
  logic [31:0]      gnt_min, gnt_max;
  logic             gnt_dir;
  logic [TICKW-1:0] gnt_ticks;
  logic             gnt_err;
  logic             grant;

  // Round-robin pick: first valid at or above rr_ptr, else first valid from 0.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    gnt_oh    = '0;
    gnt_min   = '0;
    gnt_max   = '0;
    gnt_dir   = 1'b0;
    gnt_ticks = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_any && req_valid[i] && (i >= int'(rr_ptr))) begin
        gnt_any   = 1'b1;
        gnt_idx   = 3'(i);
        gnt_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_any && req_valid[i]) begin
        gnt_any   = 1'b1;
        gnt_idx   = 3'(i);
        gnt_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) begin
        gnt_min   = req_min[32*i +: 32];
        gnt_max   = req_max[32*i +: 32];
        gnt_dir   = req_dir[i];
        gnt_ticks = req_ticks[TICKW*i +: TICKW];
      end
    end
  end

  assign gnt_err = (gnt_min > gnt_max);

  // Next-state logic and pure state decodes for the handshake and counter controls.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    clr       = 1'b0;
    cnten     = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state != S_IDLE);
    grant     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (gnt_any) begin
          grant     = 1'b1;
          req_ready = rst_n ? gnt_oh : '0;
          state_nxt = gnt_err ? S_RESP : S_LOAD;
        end
      end
      S_LOAD: begin
        clr       = 1'b1;
        state_nxt = (tick_cnt != '0) ? S_RUN : S_CAPTURE;
      end
      S_RUN: begin
        cnten = 1'b1;
        if (tick_cnt == TICKW'(1)) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, job latches and the run-length down-counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      tick_cnt  <= '0;
      rsp_id    <= '0;
      rsp_value <= '0;
      rsp_err   <= 1'b0;
      cnt_min   <= '0;
      cnt_max   <= '0;
      inc_dec   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        rr_ptr    <= (gnt_idx == 3'(NREQ-1)) ? 3'd0 : gnt_idx + 3'd1;
        rsp_id    <= gnt_idx;
        rsp_err   <= gnt_err;
        rsp_value <= '0;
        tick_cnt  <= gnt_ticks;
        // Rejected jobs leave the counter programming untouched.
        if (!gnt_err) begin
          cnt_min <= gnt_min;
          cnt_max <= gnt_max;
          inc_dec <= gnt_dir;
        end
      end
      if (state == S_RUN) tick_cnt <= tick_cnt - TICKW'(1);
      if (state == S_CAPTURE) rsp_value <= cnt_value;
    end
  end

endmodule

// File: tb/tb_counter_scheduler.sv
// Testbench for counter_scheduler: models the shared counter, runs a table
// of directed jobs, hand-written multi-cycle sequences and random jobs
// against an arithmetic reference for results, latency and grant order.
module tb_counter_scheduler;
  localparam int NREQ  = 4;
  localparam int TICKW = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [32*NREQ-1:0]    req_min;
  logic [32*NREQ-1:0]    req_max;
  logic [NREQ-1:0]       req_dir;
  logic [TICKW*NREQ-1:0] req_ticks;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [2:0]            rsp_id;
  logic [31:0]           rsp_value;
  logic                  rsp_err;
  logic                  busy;
  logic [31:0]           cnt_min;
  logic [31:0]           cnt_max;
  logic                  inc_dec;
  logic                  clr;
  logic                  cnten;
  logic [31:0]           cnt_value;

  counter_scheduler #(.NREQ(NREQ), .TICKW(TICKW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_min(req_min), .req_max(req_max), .req_dir(req_dir), .req_ticks(req_ticks),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_value(rsp_value), .rsp_err(rsp_err), .busy(busy),
    .cnt_min(cnt_min), .cnt_max(cnt_max), .inc_dec(inc_dec),
    .clr(clr), .cnten(cnten), .cnt_value(cnt_value)
  );

  always #5 clk = ~clk;

  // External wrapping counter driven by the scheduler
  logic [31:0] cval = 32'd0;
  assign cnt_value = cval;
  always @(posedge clk) begin
    if (clr) cval <= inc_dec ? cnt_min : cnt_max;
    else if (cnten) begin
      if (inc_dec) cval <= (cval == cnt_max) ? cnt_min : cval + 32'd1;
      else         cval <= (cval == cnt_min) ? cnt_max : cval - 32'd1;
    end
  end

  int cyc = 0;
  int tot_clr = 0;
  int tot_en = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (clr)   tot_clr <= tot_clr + 1;
    if (cnten) tot_en  <= tot_en + 1;
  end

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_val(input logic [31:0] mn, input logic [31:0] mx,
                                          input logic dir, input logic [TICKW-1:0] tk);
    logic [31:0] r;
    logic [31:0] m;
    r = mx - mn + 32'd1;
    m = (r == 32'd0) ? 32'(tk) : 32'(tk) % r;
    return dir ? mn + m : mx - m;
  endfunction

  function automatic int predict(input logic [NREQ-1:0] mask, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (!rsp_valid && n < 300) begin
      tick();
      n++;
    end
    if (!rsp_valid) begin
      errors++;
      $display("FAIL %s: response timeout", name);
    end
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    while (req_ready == '0 && n < 20) begin
      tick();
      n++;
    end
    if (req_ready == '0) begin
      errors++;
      $display("FAIL %s: grant timeout", name);
    end
  endtask

  task automatic set_payload(input int idx, input logic [31:0] mn, input logic [31:0] mx,
                             input logic dir, input logic [TICKW-1:0] tk);
    req_min[32*idx +: 32]       = mn;
    req_max[32*idx +: 32]       = mx;
    req_dir[idx]                = dir;
    req_ticks[TICKW*idx +: TICKW] = tk;
  endtask

  // Single-requester job with rsp_ready high; checks grant, latency, result, counter activity.
  task automatic run_job(input string name, input int idx, input logic [31:0] mn,
                         input logic [31:0] mx, input logic dir, input logic [TICKW-1:0] tk,
                         input logic [31:0] e_val, input logic e_err, input int e_lat);
    logic [31:0] pmin, pmax;
    logic        pdir;
    int          t_g, c0, e0, eg;
    tick();
    set_payload(idx, mn, mx, dir, tk);
    req_valid      = '0;
    req_valid[idx] = 1'b1;
    rsp_ready      = 1'b1;
    pmin = cnt_min; pmax = cnt_max; pdir = inc_dec;
    #1;
    eg = predict(req_valid, model_ptr);
    check({name, " grant"}, 64'(req_ready), 64'(1) << eg);
    model_ptr = (eg + 1) % NREQ;
    t_g = cyc; c0 = tot_clr; e0 = tot_en;
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_rsp(name);
    check({name, " latency"}, 64'(cyc - t_g), 64'(e_lat));
    check({name, " id"}, 64'(rsp_id), 64'(idx));
    check({name, " value"}, 64'(rsp_value), 64'(e_val));
    check({name, " err"}, 64'(rsp_err), 64'(e_err));
    check({name, " clr cycles"}, 64'(tot_clr - c0), e_err ? 64'd0 : 64'd1);
    check({name, " cnten cycles"}, 64'(tot_en - e0), e_err ? 64'd0 : 64'(tk));
    if (e_err) begin
      check({name, " bounds held"}, {cnt_min, cnt_max}, {pmin, pmax});
      check({name, " dir held"}, 64'(inc_dec), 64'(pdir));
    end
    @(posedge clk);
    #1;
    check({name, " idle after"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    int               idx;
    logic [31:0]      mn;
    logic [31:0]      mx;
    logic             dir;
    logic [TICKW-1:0] tk;
    logic [31:0]      e_val;
    logic             e_err;
    int               e_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int t_g, eg;
    logic [31:0] mn, mx;
    logic        dir, e_err;
    logic [TICKW-1:0] tk;
    int          idx;

    vecs[0] = '{0, 32'd10,  32'd13,         1'b1, 16'd6, 32'd12,         1'b0, 9};
    vecs[1] = '{2, 32'd0,   32'hFFFF_FFFF,  1'b0, 16'd3, 32'hFFFF_FFFC,  1'b0, 6};
    vecs[2] = '{1, 32'd5,   32'd4,          1'b1, 16'd2, 32'd0,          1'b1, 1};
    vecs[3] = '{3, 32'd100, 32'd104,        1'b0, 16'd7, 32'd102,        1'b0, 10};
    vecs[4] = '{0, 32'd42,  32'd42,         1'b1, 16'd5, 32'd42,         1'b0, 8};
    vecs[5] = '{3, 32'd20,  32'd30,         1'b1, 16'd0, 32'd20,         1'b0, 3};

    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    req_min = '0; req_max = '0; req_dir = '0; req_ticks = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset rsp", {rsp_valid, rsp_err, rsp_id, rsp_value}, 64'd0);
    check("reset cnt bounds", {cnt_min, cnt_max}, 64'd0);
    check("reset ctl", {req_ready, inc_dec, clr, cnten}, 64'd0);
    tick();
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++)
      run_job($sformatf("vec%0d", v), vecs[v].idx, vecs[v].mn, vecs[v].mx, vecs[v].dir,
              vecs[v].tk, vecs[v].e_val, vecs[v].e_err, vecs[v].e_lat);

    // rsp_ready held low: response stable and no new grant until after the handshake
    tick();
    set_payload(1, 32'd7, 32'd9, 1'b1, 16'd4);
    set_payload(3, 32'd55, 32'd55, 1'b0, 16'd0);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    eg = predict(req_valid, model_ptr);
    check("stall grant", 64'(req_ready), 64'(1) << eg);
    model_ptr = (eg + 1) % NREQ;
    t_g = cyc;
    @(posedge clk);
    #1;
    req_valid = 4'b1000;
    wait_rsp("stall");
    check("stall latency", 64'(cyc - t_g), 64'd7);
    for (int k = 0; k < 5; k++) begin
      check("stall hold", {rsp_valid, rsp_id, rsp_value}, {1'b1, 3'd1, 32'd8});
      check("stall no grant", 64'(req_ready), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    check("handshake cycle no grant", 64'(req_ready), 64'd0);
    tick();
    eg = predict(req_valid, model_ptr);
    check("grant after handshake", 64'(req_ready), 64'(1) << eg);
    model_ptr = (eg + 1) % NREQ;
    t_g = cyc;
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_rsp("after stall");
    check("after stall latency", 64'(cyc - t_g), 64'd3);
    check("after stall value", 64'(rsp_value), 64'd55);
    @(posedge clk);
    #1;

    // All requesters continuously valid, zero-tick jobs: round-robin order
    for (int i = 0; i < NREQ; i++) set_payload(i, 32'(i * 100 + 1), 32'(i * 100 + 50), i[0], '0);
    req_valid = '1;
    rsp_ready = 1'b1;
    tick();
    for (int g = 0; g < 8; g++) begin
      wait_grant("rr");
      eg = predict(req_valid, model_ptr);
      check("rr order", 64'(req_ready), 64'(1) << eg);
      model_ptr = (eg + 1) % NREQ;
      t_g = cyc;
      if (g == 7) begin
        @(posedge clk);
        #1;
        req_valid = '0;
      end
      wait_rsp("rr");
      check("rr latency", 64'(cyc - t_g), 64'd3);
      check("rr id", 64'(rsp_id), 64'(eg));
      check("rr value", 64'(rsp_value),
            64'(exp_val(32'(eg * 100 + 1), 32'(eg * 100 + 50), eg[0], '0)));
    end
    @(posedge clk);
    #1;

    // Reset pulse in the middle of a long run
    tick();
    set_payload(2, 32'd0, 32'd1000, 1'b1, 16'd100);
    req_valid = 4'b0100;
    #1;
    eg = predict(req_valid, model_ptr);
    check("rst job grant", 64'(req_ready), 64'(1) << eg);
    model_ptr = (eg + 1) % NREQ;
    t_g = cyc;
    @(posedge clk);
    #1;
    req_valid = '0;
    while (cyc < t_g + 20) tick();
    check("rst job running", 64'(cnten), 64'd1);
    set_payload(1, 32'd3, 32'd8, 1'b0, 16'd2);
    set_payload(3, 32'd3, 32'd8, 1'b1, 16'd2);
    req_valid = 4'b1010;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_ptr = 0;
    check("mid rst busy/ctl", {busy, clr, cnten, inc_dec, req_ready}, 64'd0);
    check("mid rst rsp", {rsp_valid, rsp_err, rsp_id, rsp_value}, 64'd0);
    check("mid rst bounds", {cnt_min, cnt_max}, 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    eg = predict(req_valid, model_ptr);
    check("post rst grant", 64'(req_ready), 64'(1) << eg);
    model_ptr = (eg + 1) % NREQ;
    t_g = cyc;
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_rsp("post rst");
    check("post rst latency", 64'(cyc - t_g), 64'd5);
    check("post rst id", 64'(rsp_id), 64'd1);
    check("post rst value", 64'(rsp_value), 64'(exp_val(32'd3, 32'd8, 1'b0, 16'd2)));
    @(posedge clk);
    #1;

    // Random single-requester jobs against the arithmetic model
    for (int r = 0; r < 40; r++) begin
      idx = $urandom_range(0, NREQ - 1);
      mn  = $urandom;
      case ($urandom_range(0, 3))
        0, 1:    mx = mn + 32'($urandom_range(0, 15));
        2:       mx = $urandom;
        default: begin mn = 32'($urandom_range(0, 5)); mx = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)); end
      endcase
      dir   = 1'($urandom_range(0, 1));
      tk    = TICKW'($urandom_range(0, 40));
      e_err = (mn > mx);
      run_job($sformatf("rand%0d", r), idx, mn, mx, dir, tk,
              e_err ? 32'd0 : exp_val(mn, mx, dir, tk), e_err, e_err ? 1 : int'(tk) + 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
